trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Machine-mode trap sequencer that acts as the initiator side of the CSR file's dedicated trap write ports (mepc, mcause, MIE disable) and its read port.
- On a committed ecall/ebreak or an enabled machine-timer interrupt, it saves state into the CSRs, fetches mtvec and redirects fetch.
- On mret, it reads mepc and redirects fetch.
- Sits between the commit stage and the CSR file; stalls the pipeline while a sequence is in flight.

Parameters:
XLEN, 64, data/PC width
CSR_AW, 12, CSR address width
CAUSE_ECALL, 11, mcause code for environment call from M-mode
CAUSE_EBREAK, 3, mcause code for breakpoint
CAUSE_MTI, 7, mcause code for machine timer interrupt (interrupt bit set)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
commit_valid_i  in  1  an instruction commits this cycle
pc_i  in  XLEN  PC of the committing instruction
next_pc_i  in  XLEN  PC of the following instruction
ecall_i  in  1  committing instruction is ecall
ebreak_i  in  1  committing instruction is ebreak
mret_i  in  1  committing instruction is mret
mtip_i  in  1  machine timer interrupt pending (mip.MTIP)
mtie_i  in  1  mie.MTIE
mstatus_ie_i  in  1  mstatus.IE (global enable)
we_mepc_o  out  1  mepc write strobe
waddr_mepc_o  out  CSR_AW  constant 12'h341
wdata_mepc_o  out  XLEN  saved PC
we_mcause_o  out  1  mcause write strobe
waddr_mcause_o  out  CSR_AW  constant 12'h342
wdata_mcause_o  out  XLEN  {intr, 58'h0, code[4:0]}
disable_mie_req_o  out  1  clear global interrupt enable
restore_mie_req_o  out  1  re-enable global interrupt enable on mret
raddr_o  out  CSR_AW  CSR read address
rdata_i  in  XLEN  CSR read data (combinational, same cycle as raddr_o)
stall_o  out  1  hold pipeline; high in every state except IDLE
redirect_o  out  1  one-cycle fetch redirect pulse
redirect_pc_o  out  XLEN  redirect target

Behaviour:
- States: IDLE, SAVE, VECTOR, RESTORE, REDIRECT. All outputs are Moore-decoded from the state plus the latched epc/cause/target registers.
- Reset (synchronous; also valid mid-sequence): state returns to IDLE, and latched epc, cause and target clear to 0.
  - All strobes = 0, stall_o = 0, redirect_o = 0, redirect_pc_o = 0, raddr_o = 0.
  - A reset during SAVE inhibits any further CSR write from that sequence.
- IDLE, evaluated only when commit_valid_i = 1, in priority order:
  - ecall_i: latch epc = pc_i, cause = {0, CAUSE_ECALL}; go to SAVE.
  - ebreak_i: latch epc = pc_i, cause = {0, CAUSE_EBREAK}; go to SAVE.
  - mret_i: go to RESTORE.
  - irq = mtip_i & mtie_i & mstatus_ie_i: latch epc = next_pc_i, cause = {1, CAUSE_MTI}; go to SAVE.
- Synchronous exceptions outrank the interrupt. A deferred interrupt is re-evaluated on the next commit in IDLE.
- Simultaneous ecall and ebreak (illegal decode): ecall wins.
- SAVE (1 cycle): we_mepc_o = we_mcause_o = disable_mie_req_o = 1, with wdata_mepc_o = epc and wdata_mcause_o = cause. Go to VECTOR.
  - The CSR file drops mepc[1:0]; this block does not mask them.
- VECTOR (1 cycle): raddr_o = 12'h305 (mtvec). Latch target = {rdata_i[63:2], 2'b00} (direct mode only). Go to REDIRECT.
- RESTORE (1 cycle): raddr_o = 12'h341 (mepc). Latch target = rdata_i; restore_mie_req_o = 1. Go to REDIRECT.
- REDIRECT (1 cycle): redirect_o = 1, redirect_pc_o = target, stall_o = 1. Go to IDLE.
- Latency: trap request to redirect pulse = 3 cycles (SAVE, VECTOR, REDIRECT); mret = 2 cycles (RESTORE, REDIRECT).
- Busy rule: commit inputs are ignored outside IDLE. Upstream must honour stall_o.
- Interrupt recheck: cause bit 63 is set only for interrupts. mstatus_ie_i falls one cycle after SAVE, so no nested trap is taken.
- Strobes are never asserted outside SAVE. raddr_o = 0 outside VECTOR and RESTORE.

Decomposition:
- Shared defines file holds:
  - CSR addresses for mepc, mcause and mtvec; these are already present.
  - Cause codes and trap state encodings; these are new, e.g. TrapIdle..TrapRedirect, 3 bits.
- Latched registers use the existing generic Reg cell.
- No further sub-module; the FSM is small enough to stay flat.

Test Plan:
- Reset, then ecall at pc_i = 0x8000_0010, mtvec = 0x8000_0100:
  - Cycle +1: we_mepc_o = 1, wdata_mepc_o = 0x8000_0010; wdata_mcause_o = 0x0000_0000_0000_000B; disable_mie_req_o = 1.
  - Cycle +3: redirect_o = 1, redirect_pc_o = 0x8000_0100.
- Timer interrupt (mtip_i = mtie_i = mstatus_ie_i = 1) with next_pc_i = 0x8000_0024, no exception -> mepc = 0x8000_0024; mcause = 0x8000_0000_0000_0007.
- mret with CSR mepc = 0x8000_0014 -> RESTORE drives raddr_o = 0x341; the next cycle gives redirect_pc_o = 0x8000_0014 with a single redirect_o pulse; stall_o is high for exactly 2 cycles.
- ecall and interrupt in the same commit -> mcause = 11, no interrupt bit; the interrupt is not taken while stall_o is high.
- mtvec = 0x8000_0103 -> redirect_pc_o = 0x8000_0100 (mode bits dropped).
- rst asserted during SAVE -> next cycle: state IDLE, all strobes 0, no redirect pulse ever emitted for that trap.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared definitions for the machine-mode trap sequencer.
//               Holds the trap CSR addresses, the sequencer state encoding,
//               the latched cause format and a helper that builds it.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

  // CSR addresses touched by the trap sequence.
  localparam logic [11:0] CSR_ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;

  // Width of the exception/interrupt code field carried in mcause.
  localparam int unsigned CAUSE_CODE_W = 5;

  // Sequencer states.
  typedef enum logic [2:0] {
    TrapIdle     = 3'd0,
    TrapSave     = 3'd1,
    TrapVector   = 3'd2,
    TrapRestore  = 3'd3,
    TrapRedirect = 3'd4
  } trap_state_e;

  // Compact cause: interrupt flag plus low code bits. Expanded to XLEN
  // only when driven onto the mcause write port.
  typedef struct packed {
    logic                    intr;
    logic [CAUSE_CODE_W-1:0] code;
  } cause_t;

  localparam int unsigned CAUSE_T_W = $bits(cause_t);

  function automatic cause_t make_cause(input logic intr, input int unsigned code);
    cause_t c;
    c.intr = intr;
    c.code = CAUSE_CODE_W'(code);
    return c;
  endfunction

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_reg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_reg
// Description : Generic register cell with synchronous active-high reset.
//               q_o takes d_i every rising edge; rst forces RESET_VAL.
// Ports       : clk, rst      - clock / synchronous reset
//               d_i  [WIDTH]  - next value
//               q_o  [WIDTH]  - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl_reg #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule : trap_ctrl_reg
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Drives the CSR file's dedicated
//               trap write ports (mepc, mcause, MIE disable/restore) and its
//               read port, and redirects fetch on ecall/ebreak, an enabled
//               machine-timer interrupt, or mret. Stalls the pipeline while
//               a sequence is in flight.
// Ports       : commit_valid_i, pc_i, next_pc_i, ecall_i, ebreak_i, mret_i
//                   - commit-stage inputs, sampled only in IDLE
//               mtip_i, mtie_i, mstatus_ie_i - interrupt qualification
//               we_/waddr_/wdata_ mepc/mcause, disable_mie_req_o,
//               restore_mie_req_o - CSR write side
//               raddr_o / rdata_i - CSR read side (combinational read)
//               stall_o, redirect_o, redirect_pc_o - pipeline control
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned CSR_AW       = 12,
  parameter int unsigned CAUSE_ECALL  = 11,
  parameter int unsigned CAUSE_EBREAK = 3,
  parameter int unsigned CAUSE_MTI    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   next_pc_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              mret_i,
  input  logic              mtip_i,
  input  logic              mtie_i,
  input  logic              mstatus_ie_i,
  output logic              we_mepc_o,
  output logic [CSR_AW-1:0] waddr_mepc_o,
  output logic [XLEN-1:0]   wdata_mepc_o,
  output logic              we_mcause_o,
  output logic [CSR_AW-1:0] waddr_mcause_o,
  output logic [XLEN-1:0]   wdata_mcause_o,
  output logic              disable_mie_req_o,
  output logic              restore_mie_req_o,
  output logic [CSR_AW-1:0] raddr_o,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  cause_t          cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            irq;

  assign irq = mtip_i & mtie_i & mstatus_ie_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TrapIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Latched sequence registers
  // --------------------------------------------------------------------------
  trap_ctrl_reg #(.WIDTH(XLEN)) u_epc_reg (
    .clk (clk),
    .rst (rst),
    .d_i (epc_d),
    .q_o (epc_q)
  );

  trap_ctrl_reg #(.WIDTH(CAUSE_T_W)) u_cause_reg (
    .clk (clk),
    .rst (rst),
    .d_i (cause_d),
    .q_o (cause_q)
  );

  trap_ctrl_reg #(.WIDTH(XLEN)) u_target_reg (
    .clk (clk),
    .rst (rst),
    .d_i (target_d),
    .q_o (target_q)
  );

  // --------------------------------------------------------------------------
  // Next-state and latch-update logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;

    case (state_q)
      TrapIdle: begin
        // Synchronous exceptions outrank the interrupt; a deferred interrupt
        // is simply seen again on a later commit.
        if (commit_valid_i) begin
          if (ecall_i) begin
            epc_d   = pc_i;
            cause_d = make_cause(1'b0, CAUSE_ECALL);
            state_d = TrapSave;
          end else if (ebreak_i) begin
            epc_d   = pc_i;
            cause_d = make_cause(1'b0, CAUSE_EBREAK);
            state_d = TrapSave;
          end else if (mret_i) begin
            state_d = TrapRestore;
          end else if (irq) begin
            // Interrupt is taken after the committing instruction completes.
            epc_d   = next_pc_i;
            cause_d = make_cause(1'b1, CAUSE_MTI);
            state_d = TrapSave;
          end
        end
      end

      TrapSave: begin
        state_d = TrapVector;
      end

      TrapVector: begin
        // Direct mode only: mtvec mode bits are discarded.
        target_d = {rdata_i[XLEN-1:2], 2'b00};
        state_d  = TrapRedirect;
      end

      TrapRestore: begin
        target_d = rdata_i;
        state_d  = TrapRedirect;
      end

      TrapRedirect: begin
        state_d = TrapIdle;
      end

      default: begin
        state_d = TrapIdle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore output decode
  // --------------------------------------------------------------------------
  assign waddr_mepc_o   = CSR_AW'(CSR_ADDR_MEPC);
  assign waddr_mcause_o = CSR_AW'(CSR_ADDR_MCAUSE);

  always_comb begin
    we_mepc_o         = 1'b0;
    we_mcause_o       = 1'b0;
    disable_mie_req_o = 1'b0;
    restore_mie_req_o = 1'b0;
    wdata_mepc_o      = '0;
    wdata_mcause_o    = '0;
    raddr_o           = '0;
    stall_o           = (state_q != TrapIdle);
    redirect_o        = 1'b0;
    redirect_pc_o     = '0;

    case (state_q)
      TrapSave: begin
        // mepc[1:0] are dropped by the CSR file itself.
        we_mepc_o         = 1'b1;
        we_mcause_o       = 1'b1;
        disable_mie_req_o = 1'b1;
        wdata_mepc_o      = epc_q;
        wdata_mcause_o    = {cause_q.intr, {(XLEN-1-CAUSE_CODE_W){1'b0}}, cause_q.code};
      end
      TrapVector: begin
        raddr_o = CSR_AW'(CSR_ADDR_MTVEC);
      end
      TrapRestore: begin
        raddr_o           = CSR_AW'(CSR_ADDR_MEPC);
        restore_mie_req_o = 1'b1;
      end
      TrapRedirect: begin
        redirect_o    = 1'b1;
        redirect_pc_o = target_q;
      end
      default: begin
      end
    endcase
  end

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl. A small CSR
//               model answers the combinational read port with mtvec/mepc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CSR_AW = 12;

  logic              clk;
  logic              rst;
  logic              commit_valid_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   next_pc_i;
  logic              ecall_i;
  logic              ebreak_i;
  logic              mret_i;
  logic              mtip_i;
  logic              mtie_i;
  logic              mstatus_ie_i;
  logic              we_mepc_o;
  logic [CSR_AW-1:0] waddr_mepc_o;
  logic [XLEN-1:0]   wdata_mepc_o;
  logic              we_mcause_o;
  logic [CSR_AW-1:0] waddr_mcause_o;
  logic [XLEN-1:0]   wdata_mcause_o;
  logic              disable_mie_req_o;
  logic              restore_mie_req_o;
  logic [CSR_AW-1:0] raddr_o;
  logic [XLEN-1:0]   rdata_i;
  logic              stall_o;
  logic              redirect_o;
  logic [XLEN-1:0]   redirect_pc_o;

  logic [XLEN-1:0]   csr_mtvec;
  logic [XLEN-1:0]   csr_mepc;

  int checks;
  int failures;

  trap_ctrl u_dut (
    .clk               (clk),
    .rst               (rst),
    .commit_valid_i    (commit_valid_i),
    .pc_i              (pc_i),
    .next_pc_i         (next_pc_i),
    .ecall_i           (ecall_i),
    .ebreak_i          (ebreak_i),
    .mret_i            (mret_i),
    .mtip_i            (mtip_i),
    .mtie_i            (mtie_i),
    .mstatus_ie_i      (mstatus_ie_i),
    .we_mepc_o         (we_mepc_o),
    .waddr_mepc_o      (waddr_mepc_o),
    .wdata_mepc_o      (wdata_mepc_o),
    .we_mcause_o       (we_mcause_o),
    .waddr_mcause_o    (waddr_mcause_o),
    .wdata_mcause_o    (wdata_mcause_o),
    .disable_mie_req_o (disable_mie_req_o),
    .restore_mie_req_o (restore_mie_req_o),
    .raddr_o           (raddr_o),
    .rdata_i           (rdata_i),
    .stall_o           (stall_o),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational CSR read model.
  always_comb begin
    rdata_i = '0;
    if (raddr_o == 12'h305) rdata_i = csr_mtvec;
    else if (raddr_o == 12'h341) rdata_i = csr_mepc;
  end

  task automatic idle_inputs();
    commit_valid_i = 1'b0;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    mtip_i = 1'b0; mtie_i = 1'b0; mstatus_ie_i = 1'b0;
    pc_i = '0; next_pc_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    checks++;
    if ({we_mepc_o, we_mcause_o, disable_mie_req_o, restore_mie_req_o, stall_o, redirect_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {we_mepc_o, we_mcause_o, disable_mie_req_o, restore_mie_req_o, stall_o, redirect_o});
    end
    checks++;
    if (raddr_o !== 12'h0 || redirect_pc_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_addr raddr=%h pc=%h exp 0/0", raddr_o, redirect_pc_o);
    end
    checks++;
    if (waddr_mepc_o !== 12'h341 || waddr_mcause_o !== 12'h342) begin
      failures++;
      $display("FAIL waddr_const mepc=%h mcause=%h exp 341/342", waddr_mepc_o, waddr_mcause_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ecall();
    csr_mtvec = 64'h8000_0100;
    commit_valid_i = 1'b1; ecall_i = 1'b1; pc_i = 64'h8000_0010; next_pc_i = 64'h8000_0014;
    step();
    idle_inputs();
    // SAVE
    checks++;
    if (we_mepc_o !== 1'b1 || we_mcause_o !== 1'b1 || disable_mie_req_o !== 1'b1 || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL ecall_save_strobes we_mepc=%b we_mcause=%b dis=%b stall=%b exp 1111",
               we_mepc_o, we_mcause_o, disable_mie_req_o, stall_o);
    end
    checks++;
    if (wdata_mepc_o !== 64'h8000_0010 || wdata_mcause_o !== 64'h0000_0000_0000_000B) begin
      failures++;
      $display("FAIL ecall_save_data mepc=%h mcause=%h exp 80000010/b", wdata_mepc_o, wdata_mcause_o);
    end
    step();
    // VECTOR
    checks++;
    if (raddr_o !== 12'h305 || stall_o !== 1'b1 || we_mepc_o !== 1'b0 || redirect_o !== 1'b0) begin
      failures++;
      $display("FAIL ecall_vector raddr=%h stall=%b we=%b redir=%b exp 305/1/0/0",
               raddr_o, stall_o, we_mepc_o, redirect_o);
    end
    step();
    // REDIRECT
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 64'h8000_0100 || stall_o !== 1'b1 || raddr_o !== 12'h0) begin
      failures++;
      $display("FAIL ecall_redirect redir=%b pc=%h stall=%b raddr=%h exp 1/80000100/1/0",
               redirect_o, redirect_pc_o, stall_o, raddr_o);
    end
    step();
    checks++;
    if (redirect_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL ecall_done redir=%b stall=%b exp 0/0", redirect_o, stall_o);
    end
  endtask

  task automatic test_timer_irq();
    // Masked by global enable: no trap.
    commit_valid_i = 1'b1; mtip_i = 1'b1; mtie_i = 1'b1; mstatus_ie_i = 1'b0;
    pc_i = 64'h8000_0020; next_pc_i = 64'h8000_0024;
    step();
    checks++;
    if (stall_o !== 1'b0 || we_mepc_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked stall=%b we=%b exp 0/0", stall_o, we_mepc_o);
    end
    mstatus_ie_i = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (we_mepc_o !== 1'b1 || wdata_mepc_o !== 64'h8000_0024 || wdata_mcause_o !== 64'h8000_0000_0000_0007) begin
      failures++;
      $display("FAIL irq_save we=%b mepc=%h mcause=%h exp 1/80000024/8000000000000007",
               we_mepc_o, wdata_mepc_o, wdata_mcause_o);
    end
    step(); step();
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 64'h8000_0100) begin
      failures++;
      $display("FAIL irq_redirect redir=%b pc=%h exp 1/80000100", redirect_o, redirect_pc_o);
    end
    step();
  endtask

  task automatic test_mret();
    int stall_cycles;
    int pulses;
    csr_mepc = 64'h8000_0014;
    stall_cycles = 0; pulses = 0;
    commit_valid_i = 1'b1; mret_i = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (raddr_o !== 12'h341 || restore_mie_req_o !== 1'b1 || we_mepc_o !== 1'b0 || redirect_o !== 1'b0) begin
      failures++;
      $display("FAIL mret_restore raddr=%h restore=%b we=%b redir=%b exp 341/1/0/0",
               raddr_o, restore_mie_req_o, we_mepc_o, redirect_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (stall_o) stall_cycles++;
      if (redirect_o) begin
        pulses++;
        checks++;
        if (redirect_pc_o !== 64'h8000_0014) begin
          failures++;
          $display("FAIL mret_target pc=%h exp 80000014", redirect_pc_o);
        end
      end
      step();
    end
    checks++;
    if (stall_cycles != 2 || pulses != 1) begin
      failures++;
      $display("FAIL mret_counts stall_cycles=%0d pulses=%0d exp 2/1", stall_cycles, pulses);
    end
  endtask

  task automatic test_ecall_irq();
    csr_mtvec = 64'h8000_0100;
    // Hold commit and interrupt high throughout the sequence.
    commit_valid_i = 1'b1; ecall_i = 1'b1; mtip_i = 1'b1; mtie_i = 1'b1; mstatus_ie_i = 1'b1;
    pc_i = 64'h8000_0030; next_pc_i = 64'h8000_0034;
    step();
    ecall_i = 1'b0;
    checks++;
    if (wdata_mcause_o !== 64'd11 || wdata_mepc_o !== 64'h8000_0030) begin
      failures++;
      $display("FAIL ecall_irq_cause mcause=%h mepc=%h exp b/80000030", wdata_mcause_o, wdata_mepc_o);
    end
    step();
    checks++;
    if (raddr_o !== 12'h305 || we_mepc_o !== 1'b0) begin
      failures++;
      $display("FAIL ecall_irq_busy raddr=%h we=%b exp 305/0", raddr_o, we_mepc_o);
    end
    step();
    checks++;
    if (redirect_o !== 1'b1 || we_mepc_o !== 1'b0) begin
      failures++;
      $display("FAIL ecall_irq_redirect redir=%b we=%b exp 1/0", redirect_o, we_mepc_o);
    end
    idle_inputs();
    step();
    checks++;
    if (stall_o !== 1'b0 || we_mepc_o !== 1'b0) begin
      failures++;
      $display("FAIL ecall_irq_idle stall=%b we=%b exp 0/0", stall_o, we_mepc_o);
    end
  endtask

  task automatic test_ebreak_mtvec_mode();
    csr_mtvec = 64'h8000_0103;
    commit_valid_i = 1'b1; ebreak_i = 1'b1; pc_i = 64'h8000_0040;
    step();
    idle_inputs();
    checks++;
    if (wdata_mcause_o !== 64'd3 || wdata_mepc_o !== 64'h8000_0040) begin
      failures++;
      $display("FAIL ebreak_save mcause=%h mepc=%h exp 3/80000040", wdata_mcause_o, wdata_mepc_o);
    end
    step(); step();
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 64'h8000_0100) begin
      failures++;
      $display("FAIL mtvec_mode redir=%b pc=%h exp 1/80000100", redirect_o, redirect_pc_o);
    end
    step();
  endtask

  task automatic test_ecall_ebreak();
    commit_valid_i = 1'b1; ecall_i = 1'b1; ebreak_i = 1'b1; pc_i = 64'h8000_0050;
    step();
    idle_inputs();
    checks++;
    if (wdata_mcause_o !== 64'd11) begin
      failures++;
      $display("FAIL ecall_ebreak_prio mcause=%h exp b", wdata_mcause_o);
    end
    step(); step(); step();
  endtask

  task automatic test_no_commit();
    commit_valid_i = 1'b0; ecall_i = 1'b1; pc_i = 64'h8000_0060;
    step();
    idle_inputs();
    checks++;
    if (stall_o !== 1'b0 || we_mepc_o !== 1'b0) begin
      failures++;
      $display("FAIL no_commit stall=%b we=%b exp 0/0", stall_o, we_mepc_o);
    end
  endtask

  task automatic test_reset_in_save();
    int pulses;
    pulses = 0;
    commit_valid_i = 1'b1; ecall_i = 1'b1; pc_i = 64'h8000_0070;
    step();
    idle_inputs();
    checks++;
    if (we_mepc_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_save_entry we=%b exp 1", we_mepc_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({we_mepc_o, we_mcause_o, disable_mie_req_o, stall_o, raddr_o} !== {4'b0, 12'h0}) begin
      failures++;
      $display("FAIL rst_save_idle we=%b%b dis=%b stall=%b raddr=%h exp all 0",
               we_mepc_o, we_mcause_o, disable_mie_req_o, stall_o, raddr_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (redirect_o || we_mepc_o) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_save_no_redirect events=%0d exp 0", pulses);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    csr_mtvec = '0;
    csr_mepc = '0;
    test_reset();
    test_ecall();
    test_timer_irq();
    test_mret();
    test_ecall_irq();
    test_ebreak_mtvec_mode();
    test_ecall_ebreak();
    test_no_commit();
    test_reset_in_save();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_trap_ctrl
`default_nettype wire
